// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between the instruction
// master and the data master. Grants one request per cycle, remembers the
// owner of every accepted request in an in-order tag FIFO, and routes each
// downstream response back to the master that issued it.
module sram_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        proto_err
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // Tag encoding: 0 means the instruction master owns the entry, 1 the data master.
  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  logic [OUTSTANDING-1:0] tag_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic [SW-1:0]          starve_q;
  logic                   proto_err_q;

  logic full;
  logic empty;
  logic starved;
  logic grant_inst;
  logic push;
  logic pop;
  logic stray;
  logic head_tag;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Full is taken from the registered count only, so a response arriving
  // this cycle can never open a combinational path back to mem_req.
  assign full     = (count_q == CW'(OUTSTANDING));
  assign empty    = (count_q == '0);
  assign starved  = (starve_q == SW'(STARVE_MAX));
  assign head_tag = tag_q[rd_ptr_q];

  // Grant selection and request-field mux: data normally wins a tie, but a
  // starved instruction master is forced through.
  always_comb begin
    grant_inst = 1'b0;
    mem_wr     = data_sram_wr;
    mem_size   = data_sram_size;
    mem_wstrb  = data_sram_wstrb;
    mem_addr   = data_sram_addr;
    mem_wdata  = data_sram_wdata;
    if (inst_sram_req && (!data_sram_req || starved)) begin
      grant_inst = 1'b1;
    end
    if (grant_inst) begin
      mem_wr    = inst_sram_wr;
      mem_size  = inst_sram_size;
      mem_wstrb = inst_sram_wstrb;
      mem_addr  = inst_sram_addr;
      mem_wdata = inst_sram_wdata;
    end
  end

  // Address handshake: the request goes out whenever a tag slot is free, and
  // only the granted master sees the acceptance. Everything is gated off while
  // reset is held low.
  always_comb begin
    mem_req           = 1'b0;
    push              = 1'b0;
    inst_sram_addr_ok = 1'b0;
    data_sram_addr_ok = 1'b0;
    if (resetn) begin
      mem_req = (inst_sram_req | data_sram_req) & ~full;
      push    = mem_req & mem_addr_ok;
      inst_sram_addr_ok = push & grant_inst;
      data_sram_addr_ok = push & ~grant_inst;
    end
  end

  // Response routing: the oldest outstanding tag decides which master gets
  // this data_ok; a response with nothing outstanding goes nowhere.
  always_comb begin
    pop               = 1'b0;
    stray             = 1'b0;
    inst_sram_data_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    if (resetn && mem_data_ok) begin
      if (empty) begin
        stray = 1'b1;
      end else begin
        pop = 1'b1;
        inst_sram_data_ok = (head_tag == TAG_INST);
        data_sram_data_ok = (head_tag == TAG_DATA);
      end
    end
  end

  // Read data is broadcast; the data_ok strobes say who should take it.
  assign inst_sram_rdata = mem_rdata;
  assign data_sram_rdata = mem_rdata;

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Tag FIFO storage and circular pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= grant_inst ? TAG_INST : TAG_DATA;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // Starvation counter: counts data wins while inst is waiting, and forgets
  // as soon as inst is served or stops asking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else if (!inst_sram_req) begin
      starve_q <= '0;
    end else if (push && grant_inst) begin
      starve_q <= '0;
    end else if (push && !starved) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // Sticky protocol error: a response showed up with nothing outstanding.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err_q <= 1'b0;
    end else if (stray) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed scenarios plus randomized traffic for sram_arbiter,
// checked cycle by cycle against a queue-based model of the arbiter's rules.
module tb_sram_arbiter;

  localparam int OUT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        inst_sram_req = 1'b0;
  logic        inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = '0;
  logic [3:0]  inst_sram_wstrb = '0;
  logic [31:0] inst_sram_addr = '0;
  logic [31:0] inst_sram_wdata = '0;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_req = 1'b0;
  logic        data_sram_wr = 1'b0;
  logic [1:0]  data_sram_size = '0;
  logic [3:0]  data_sram_wstrb = '0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        proto_err;

  // Reference model state: owners of outstanding requests, oldest first.
  int q[$];
  int starve;
  bit proto;

  int errors = 0;
  int checks = 0;

  sram_arbiter #(.OUTSTANDING(OUT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge; fields are random.
  task automatic applyStimulus(input bit ireq, input bit dreq, input bit aok,
                               input bit dok, input logic [31:0] rdata);
    @(negedge clk);
    inst_sram_req   = ireq;
    data_sram_req   = dreq;
    mem_addr_ok     = aok;
    mem_data_ok     = dok;
    mem_rdata       = rdata;
    inst_sram_wr    = 1'($urandom);
    inst_sram_size  = 2'($urandom);
    inst_sram_wstrb = 4'($urandom);
    inst_sram_addr  = $urandom;
    inst_sram_wdata = $urandom;
    data_sram_wr    = 1'($urandom);
    data_sram_size  = 2'($urandom);
    data_sram_wstrb = 4'($urandom);
    data_sram_addr  = $urandom;
    data_sram_wdata = $urandom;
  endtask

  // Compare the settled outputs with the model, then advance the model to
  // what the coming rising edge should leave behind.
  task automatic checkOutput();
    bit inst_wins, exp_req, exp_acc, exp_pop;
    int head;
    #1;
    inst_wins = inst_sram_req && (!data_sram_req || starve == SMAX);
    exp_req   = (inst_sram_req || data_sram_req) && (q.size() < OUT);
    exp_acc   = exp_req && mem_addr_ok;
    exp_pop   = mem_data_ok && (q.size() > 0);
    head      = (q.size() > 0) ? q[0] : 0;

    compare("mem_req", 71'(mem_req), 71'(exp_req));
    compare("inst_addr_ok", 71'(inst_sram_addr_ok), 71'(exp_acc && inst_wins));
    compare("data_addr_ok", 71'(data_sram_addr_ok), 71'(exp_acc && !inst_wins));
    compare("inst_data_ok", 71'(inst_sram_data_ok), 71'(exp_pop && head == 0));
    compare("data_data_ok", 71'(data_sram_data_ok), 71'(exp_pop && head == 1));
    compare("rdata", {7'd0, inst_sram_rdata, data_sram_rdata}, {7'd0, mem_rdata, mem_rdata});
    compare("proto_err", 71'(proto_err), 71'(proto));
    if (inst_sram_req || data_sram_req) begin
      if (inst_wins)
        compare("fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
                {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata});
      else
        compare("fields", {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
                {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata});
    end

    if (mem_data_ok && q.size() == 0) proto = 1'b1;
    if (exp_pop) void'(q.pop_front());
    if (exp_acc) q.push_back(inst_wins ? 0 : 1);
    if (!inst_sram_req || (exp_acc && inst_wins)) starve = 0;
    else if (exp_acc && starve < SMAX) starve = starve + 1;
  endtask

  task automatic cycle(input bit ireq, input bit dreq, input bit aok,
                       input bit dok, input logic [31:0] rdata);
    applyStimulus(ireq, dreq, aok, dok, rdata);
    checkOutput();
  endtask

  // Assert reset asynchronously with busy inputs, check everything is forced
  // quiet, then release on a falling edge.
  task automatic doReset();
    @(negedge clk);
    #2;
    resetn        = 1'b0;
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    mem_addr_ok   = 1'b1;
    mem_data_ok   = 1'b1;
    mem_rdata     = $urandom;
    #1;
    compare("rst_mem_req", 71'(mem_req), 71'(0));
    compare("rst_addr_ok", 71'({inst_sram_addr_ok, data_sram_addr_ok}), 71'(0));
    compare("rst_data_ok", 71'({inst_sram_data_ok, data_sram_data_ok}), 71'(0));
    compare("rst_proto_err", 71'(proto_err), 71'(0));
    compare("rst_rdata", {7'd0, inst_sram_rdata, data_sram_rdata}, {7'd0, mem_rdata, mem_rdata});
    q.delete();
    starve = 0;
    proto  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    mem_addr_ok   = 1'b0;
    mem_data_ok   = 1'b0;
    resetn        = 1'b1;
  endtask

  initial begin
    logic [6:0] seen;
    bit ir, dr, dk;

    doReset();

    $display("[TB] single instruction read");
    applyStimulus(1, 0, 0, 0, 32'h0);
    inst_sram_addr = 32'h1c000000;
    checkOutput();
    applyStimulus(1, 0, 1, 0, 32'h0);
    inst_sram_addr = 32'h1c000000;
    checkOutput();
    compare("single_addr", 71'(mem_addr), 71'(32'h1c000000));
    cycle(0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 32'h02800000);
    compare("single_rdata", 71'(inst_sram_rdata), 71'(32'h02800000));

    $display("[TB] contention");
    applyStimulus(1, 1, 1, 0, 32'h0);
    data_sram_addr = 32'h1c001000;
    checkOutput();
    compare("contend_data_first", 71'(data_sram_addr_ok), 71'(1));
    cycle(1, 0, 1, 0, 32'h0);
    cycle(0, 0, 1, 0, 32'h0);
    cycle(0, 0, 1, 1, 32'h11111111);
    cycle(0, 0, 1, 1, 32'h22222222);

    $display("[TB] tag FIFO full");
    cycle(1, 0, 1, 0, 32'h0);
    cycle(0, 1, 1, 0, 32'h0);
    cycle(1, 0, 1, 0, 32'h0);
    compare("full_blocks", 71'({mem_req, inst_sram_addr_ok}), 71'(0));
    cycle(1, 0, 1, 0, 32'h0);
    cycle(1, 0, 1, 1, 32'h33333333);
    compare("full_pop_same_cycle", 71'(mem_req), 71'(0));
    cycle(1, 0, 1, 0, 32'h0);
    compare("full_third_accept", 71'(inst_sram_addr_ok), 71'(1));
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);

    $display("[TB] starvation");
    doReset();
    for (int k = 0; k < 7; k++) begin
      cycle(1, 1, 1, k > 0, $urandom);
      seen[k] = data_sram_addr_ok;
    end
    compare("starve_pattern", 71'(seen), 71'(7'b1101111));
    cycle(0, 0, 0, 1, $urandom);

    $display("[TB] pointer wrap");
    for (int k = 0; k < 10; k++) cycle(k % 2 == 0, k % 2 == 1, 1, k > 0, $urandom);
    cycle(0, 0, 0, 1, $urandom);
    compare("wrap_drained", 71'(q.size()), 71'(0));
    cycle(1, 1, 1, 0, $urandom);
    cycle(1, 0, 1, 0, $urandom);
    cycle(1, 1, 1, 0, $urandom);
    compare("wrap_count_two", 71'(mem_req), 71'(0));
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 1, $urandom);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      dk = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      cycle(ir, dr, 1'($urandom), dk, $urandom);
    end
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, q.size() > 0, $urandom);

    $display("[TB] stray response");
    cycle(0, 0, 0, 1, $urandom);
    cycle(0, 0, 0, 0, $urandom);
    compare("stray_sets_proto", 71'(proto_err), 71'(1));
    cycle(1, 0, 1, 0, $urandom);
    cycle(0, 0, 0, 1, $urandom);
    compare("stray_sticky", 71'(proto_err), 71'(1));
    doReset();
    cycle(0, 0, 0, 0, $urandom);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-to-one arbiter that shares the single SRAM-like memory port (toward the AXI bridge) between the fetch stage's instruction port and the memory stage's data port. It accepts requests from both masters, grants one per cycle, and records the owner of every accepted request in an in-order tag FIFO. Each downstream `data_ok`/`rdata` is routed back to the master that issued it. It sits in the CPU top, between `if_stage`/`exe_stage` and the bridge.

## Interface
Parameters:
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered requests (tag FIFO depth); legal 1..8.
- `STARVE_MAX`, default 4: consecutive data grants allowed while inst is waiting before inst is forced.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `inst_sram_req/wr/size/wstrb/addr/wdata`  in  1/1/2/4/32/32  instruction master request fields.
- `inst_sram_addr_ok`, `inst_sram_data_ok`  out  1  handshakes to the instruction master.
- `inst_sram_rdata`  out  32  read data to the instruction master.
- `data_sram_req/wr/size/wstrb/addr/wdata`  in  1/1/2/4/32/32  data master request fields.
- `data_sram_addr_ok`, `data_sram_data_ok`  out  1  handshakes to the data master.
- `data_sram_rdata`  out  32  read data to the data master.
- `mem_req/wr/size/wstrb/addr/wdata`  out  1/1/2/4/32/32  shared downstream request.
- `mem_addr_ok`, `mem_data_ok`  in  1  downstream handshakes.
- `mem_rdata`  in  32  downstream read data.
- `proto_err`  out  1  sticky: `mem_data_ok` arrived with the FIFO empty.

## Operation
- Request accept: `mem_req && mem_addr_ok` in one cycle. Response: `mem_data_ok` high. Responses arrive in request order.
- Grant is combinational each cycle:
  - Data wins when both masters request.
  - Exception: inst wins when `starve_cnt == STARVE_MAX` and `inst_sram_req` is high.
- `mem_req = (inst_sram_req | data_sram_req) & ~full`.
- Request fields are muxed from the granted master.
- Fields may change between cycles before acceptance. Downstream samples fields only on acceptance.
- Address handshake routing:
  - Granted master: `*_addr_ok = mem_addr_ok & mem_req`.
  - Loser: `*_addr_ok = 0`.
- Tag FIFO: 1-bit tags (0 = inst, 1 = data), circular, `OUTSTANDING` entries.
  - Read/write pointers and a count of width clog2(`OUTSTANDING`+1).
  - Push the granted tag on request accept.
  - Pop on `mem_data_ok` when not empty.
- Response routing:
  - Head tag 0: `inst_sram_data_ok = mem_data_ok`.
  - Head tag 1: `data_sram_data_ok = mem_data_ok`.
  - The other master's `data_ok = 0`.
  - Both `*_rdata = mem_rdata` unconditionally.
- `full` is derived from the registered count only. Push is blocked when full even if a pop happens the same cycle (no combinational data_ok → req path).
- Simultaneous push and pop when not full: count unchanged, both pointers advance, wrap modulo `OUTSTANDING`.
- `mem_data_ok` with FIFO empty:
  - No upstream `data_ok`, no pointer change.
  - `proto_err` is set and stays 1 until reset.
- Starvation counter `starve_cnt` (0..`STARVE_MAX`):
  - +1 when data is accepted while `inst_sram_req` is high.
  - Cleared when inst is accepted, or when `inst_sram_req` is low.
  - Saturates at `STARVE_MAX`.

## Timing
- Address path is zero-latency combinational: master req → `mem_req` → `mem_addr_ok` → master `addr_ok` in the same cycle.
- Response path is zero-latency combinational: `mem_data_ok` → routed `*_data_ok` in the same cycle.
- Tag push/pop take effect at the next edge. A response may not arrive in the same cycle as its own request accept (bridge guarantee); a response in the next cycle is legal.
- Reset (`resetn` low, async): count, pointers, `starve_cnt` and `proto_err` clear immediately. While low:
  - `mem_req`, all `*_addr_ok` and all `*_data_ok` are forced to 0.
  - `rdata` outputs pass `mem_rdata` through.
- Reset mid-transaction discards outstanding tags. The bridge shares `resetn`, so no stale response returns.
- Release of `resetn` is synchronous in effect: the first grant occurs on the first cycle `resetn` samples high.

## Test plan
- Single inst read:
  - Stimulus: inst req addr 0x1c000000; `mem_addr_ok` at cycle 1; `mem_data_ok` at cycle 3 with rdata 0x02800000.
  - Response: `inst_sram_addr_ok` at cycle 1; `inst_sram_data_ok` at cycle 3 with rdata 0x02800000; `data_sram_data_ok` stays 0.
- Contention:
  - Stimulus: both masters request at cycle 0 (data addr 0x1c001000); `mem_addr_ok` always 1.
  - Response: data accepted cycle 0, inst cycle 1. Two responses at cycles 3 and 4 return data-then-inst.
- FIFO full, `OUTSTANDING`=2:
  - Stimulus: two requests accepted; third inst request held with no response pending.
  - Response: `mem_req` = 0 and `inst_sram_addr_ok` = 0 until the first `mem_data_ok`. The third request is accepted the cycle after.
- Starvation, `STARVE_MAX`=4:
  - Stimulus: both requests held high; `mem_addr_ok` = 1.
  - Response: 4 data accepts, inst accepted on the 5th cycle, then data resumes.
- Pointer wrap:
  - Stimulus: 10 alternating inst/data requests, each answered one cycle later.
  - Response: every `data_ok` routed to the correct master; count returns to 0.
- Stray response:
  - Stimulus: `mem_data_ok` pulse with the FIFO empty.
  - Response: no upstream `data_ok`; `proto_err` = 1, held until `resetn` low.
